// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if
//   Start/result handshake between the execute stage and the iterative
//   multiply/divide unit.
//   valid_i    execute -> MDU  one-cycle start pulse
//   MDU_op_i   execute -> MDU  RV32M func3, captured with valid_i
//   MDU_RS1_i  execute -> MDU  rs1 operand (multiplicand/dividend)
//   MDU_RS2_i  execute -> MDU  rs2 operand (multiplier/divisor)
//   ready_o    MDU -> execute  one-cycle pulse, MDU_RD_o valid this cycle
//   MDU_RD_o   MDU -> execute  result, held until the next result
//   master modport: execute side; slave modport: the MDU.
interface mul_div_unit_if #(
    parameter int XLEN = 32
);
    logic            valid_i;
    logic [2:0]      MDU_op_i;
    logic [XLEN-1:0] MDU_RS1_i;
    logic [XLEN-1:0] MDU_RS2_i;
    logic            ready_o;
    logic [XLEN-1:0] MDU_RD_o;

    modport master (
        output valid_i, MDU_op_i, MDU_RS1_i, MDU_RS2_i,
        input  ready_o, MDU_RD_o
    );

    modport slave (
        input  valid_i, MDU_op_i, MDU_RS1_i, MDU_RS2_i,
        output ready_o, MDU_RD_o
    );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Iterative RV32M multiply/divide unit. Multiplies by shift-add and divides
//   by restoring division, one bit per cycle, on operand magnitudes; the sign
//   is applied once at the end. Divide-by-zero and signed overflow skip the
//   iterations and answer in the following cycle.
//   clk   core clock, rising edge
//   rst   synchronous, active-high reset (aborts an op in flight)
//   bus   mul_div_unit_if.slave: valid_i/MDU_op_i/MDU_RS1_i/MDU_RS2_i in,
//         ready_o/MDU_RD_o out
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    mul_div_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [2:0]        op_q;
    logic [XLEN-1:0]   opb_q;     // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc_q;     // mul: {partial hi, multiplier}; div: {remainder, quotient}
    logic              neg_q;     // negate the selected result in DONE
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   rd_q;

    // ---------------- operand decode at capture ----------------
    logic            rs1_signed, rs2_signed, sign1, sign2;
    logic [XLEN-1:0] abs1, abs2;
    logic            div_zero, div_ovf, special;

    always_comb begin
        rs1_signed = (bus.MDU_op_i == 3'b001) || (bus.MDU_op_i == 3'b010) ||
                     (bus.MDU_op_i == 3'b100) || (bus.MDU_op_i == 3'b110);
        rs2_signed = (bus.MDU_op_i == 3'b001) || (bus.MDU_op_i == 3'b100) ||
                     (bus.MDU_op_i == 3'b110);
        sign1      = rs1_signed && bus.MDU_RS1_i[XLEN-1];
        sign2      = rs2_signed && bus.MDU_RS2_i[XLEN-1];
        abs1       = sign1 ? -bus.MDU_RS1_i : bus.MDU_RS1_i;
        abs2       = sign2 ? -bus.MDU_RS2_i : bus.MDU_RS2_i;
        div_zero   = bus.MDU_op_i[2] && (bus.MDU_RS2_i == '0);
        div_ovf    = bus.MDU_op_i[2] && !bus.MDU_op_i[0] &&
                     (bus.MDU_RS1_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (bus.MDU_RS2_i == '1);
        special    = div_zero || div_ovf;
    end

    // ---------------- one iteration step ----------------
    logic              last_iter;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] mul_next, div_next;

    always_comb begin
        last_iter = (cnt_q == CW'(XLEN-1));
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        // Remainder shifted left with the next dividend bit brought in.
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opb_q};
        // div_shift < 2*divisor, so the top bit of the difference is the borrow.
        if (!div_diff[XLEN])
            div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
            div_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end

    // ---------------- sign fix-up and result select ----------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, result;

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 result = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         result = quo_fix;
            default:                result = rem_fix;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    logic            ready;
    logic [XLEN-1:0] rd;

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        rd        = rd_q;
        case (state)
            S_IDLE: begin
                if (bus.valid_i) begin
                    if (special)              state_nxt = S_DONE;
                    else if (bus.MDU_op_i[2]) state_nxt = S_DIV;
                    else                      state_nxt = S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                if (last_iter) state_nxt = S_DONE;
            end
            S_DONE: begin
                ready     = 1'b1;
                rd        = result;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.ready_o  = ready;
    assign bus.MDU_RD_o = rd;

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= '0;
            opb_q <= '0;
            acc_q <= '0;
            neg_q <= 1'b0;
            cnt_q <= '0;
            rd_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.valid_i) begin
                        op_q  <= bus.MDU_op_i;
                        cnt_q <= '0;
                        // Special cases are preloaded so DONE's normal select
                        // produces the architecturally defined value.
                        if (div_zero) begin
                            acc_q <= {bus.MDU_RS1_i, {XLEN{1'b1}}};
                            opb_q <= '0;
                            neg_q <= 1'b0;
                        end else if (div_ovf) begin
                            acc_q <= {{XLEN{1'b0}}, bus.MDU_RS1_i};
                            opb_q <= '0;
                            neg_q <= 1'b0;
                        end else begin
                            if (bus.MDU_op_i[2]) begin
                                acc_q <= {{XLEN{1'b0}}, abs1};
                                opb_q <= abs2;
                            end else begin
                                acc_q <= {{XLEN{1'b0}}, abs2};
                                opb_q <= abs1;
                            end
                            neg_q <= (bus.MDU_op_i == 3'b110) ? sign1 : (sign1 ^ sign2);
                        end
                    end
                end
                S_MUL: begin
                    acc_q <= mul_next;
                    cnt_q <= cnt_q + 1'b1;
                end
                S_DIV: begin
                    acc_q <= div_next;
                    cnt_q <= cnt_q + 1'b1;
                end
                S_DONE: begin
                    rd_q <= result;
                end
                default: ;
            endcase
        end
    end
endmodule
